register_file_read_control: RTL and testbench
=============================================

Name: register_file_read_control

Overview:
- Read-side counterpart of the register-file writeback control; fetches source operands for the current instruction.
- The register file has a single asynchronous read port, so rs1 and rs2 are read sequentially, one per cycle, under a small FSM.
- Sits between the decoder (opcode, rs1, rs2) and the ALU/branch/store datapath.
- The stage sequencer holds STAGE_REGISTER_READ until operands_valid is seen.

Parameters:
- XLEN, 32, data width of register values.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stage  in  `STAGE_WIDTH  current CPU stage.
- opcode  in  7  instruction opcode.
- rs1  in  REG_ADDR_W  source register 1 index.
- rs2  in  REG_ADDR_W  source register 2 index.
- rf_read_addr  out  REG_ADDR_W  register-file read address (combinational from state).
- rf_read_data  in  XLEN  register-file read data (asynchronous read).
- wb_write_enable  in  1  writeback strobe (used only with the bypass feature).
- wb_rd  in  REG_ADDR_W  writeback destination index.
- wb_value  in  XLEN  writeback data.
- rs1_value  out  XLEN  captured rs1 operand.
- rs2_value  out  XLEN  captured rs2 operand.
- operands_valid  out  1  both required operands are captured.
- busy  out  1  FSM is not IDLE and not DONE.

Behaviour:
- Operand needs, decoded from opcode:
  - OP, BRANCH, STORE: rs1 and rs2.
  - OP_IMM, LOAD, JALR: rs1 only.
  - LUI, AUIPC, JAL, any other opcode: none.
- States: IDLE, RD_RS1, RD_RS2, DONE.
- IDLE:
  - Start condition: stage==STAGE_REGISTER_READ.
  - On start: latch rs1/rs2/needs and clear rs1_value and rs2_value to 0.
  - Next state: RD_RS1 if rs1 is needed, otherwise DONE.
- RD_RS1: rf_read_addr = latched rs1; capture into rs1_value; next state RD_RS2 if rs2 is needed, otherwise DONE.
- RD_RS2: rf_read_addr = latched rs2; capture into rs2_value; next state DONE.
- DONE: operands_valid=1 (equals state==DONE); hold until stage != STAGE_REGISTER_READ, then go to IDLE.
- rf_read_addr = 0 in IDLE and DONE.
- Latency, start seen in cycle N:
  - Two operands: valid at N+3.
  - One operand: valid at N+2.
  - No operands: valid at N+1.
- Index x0: the captured value is 0 regardless of rf_read_data.
- Unneeded operands stay 0.
- If stage leaves STAGE_REGISTER_READ in RD_RS1 or RD_RS2: abort to IDLE next cycle. operands_valid is never asserted and captured values are retained (they are cleared at the next start).
- Reset (any state, including mid-read):
  - State goes to IDLE.
  - rs1_value, rs2_value, operands_valid and busy go to 0.
  - rf_read_addr goes to 0.
- Opcode/rs changes after start are ignored; the latched copies are used.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Enabled: during capture, if wb_write_enable && wb_rd==current read index && index!=0, capture wb_value instead of rf_read_data. This holds for both RD_RS1 and RD_RS2.
- Disabled: wb_* inputs are ignored; capture always uses rf_read_data (x0 still forced to 0).
- Ports exist in both builds.

Decomposition:
- Shared arch_defines: opcode constants, STAGE_* constants, and FSM state encodings (2-bit, under a new RFR_STATE_* group).
- One natural sub-module: operand_usage_decode, combinational opcode -> {need_rs1, need_rs2}. It is reusable by hazard logic.

Test Plan:
1. ADD x3,x1,x2 with x1=5, x2=7:
   - Stage enters REGISTER_READ at cycle 0.
   - rf_read_addr is 1 at cycle 1 and 2 at cycle 2.
   - operands_valid at cycle 3 with rs1_value=5, rs2_value=7.
2. ADDI with rs1=x4=0xDEADBEEF: valid at cycle 2 with rs1_value=0xDEADBEEF and rs2_value=0.
3. LUI: valid at cycle 1 with both values 0; rf_read_addr stays 0 throughout.
4. BEQ x0,x6 with the RF model returning 0xFFFFFFFF for every address: rs1_value=0, rs2_value=0xFFFFFFFF.
5. Reset asserted in RD_RS1: next cycle state is IDLE, valid=0, values 0. Stage dropped in RD_RS2: next cycle IDLE with no valid pulse.
6. RF_BYPASS_EN: in RD_RS1 with rs1=x9, drive wb_write_enable=1, wb_rd=9, wb_value=0x12345678 while the RF returns 0x1.
   - Enabled: rs1_value=0x12345678.
   - Disabled: rs1_value=0x1.
   - With wb_rd=0, either build: the value follows the normal rule.

Source files
------------

// File: rtl/register_file_read_control_pkg.sv
// Shared architectural definitions for the register-file read control slice.
// Contents:
//   - STAGE_WIDTH and the STAGE_* CPU stage encodings.
//   - OPCODE_* constants (RV32I major opcodes).
//   - rfr_state_e: 2-bit state encoding of the operand-read FSM (RFR_STATE_*).
package register_file_read_control_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_FETCH         = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_DECODE        = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_REGISTER_READ = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_EXECUTE       = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEMORY        = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITEBACK     = 3'd5;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    RFR_STATE_IDLE   = 2'd0,
    RFR_STATE_RD_RS1 = 2'd1,
    RFR_STATE_RD_RS2 = 2'd2,
    RFR_STATE_DONE   = 2'd3
  } rfr_state_e;

endpackage

// File: rtl/register_file_read_control_operand_usage_decode.sv
// Combinational opcode -> source-operand usage decode. Also usable by hazard
// detection logic, which needs the same "which sources are read" answer.
// Ports:
//   opcode   in  7  instruction opcode
//   need_rs1 out 1  instruction reads rs1
//   need_rs2 out 1  instruction reads rs2
module operand_usage_decode
  import register_file_read_control_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       need_rs1,
  output logic       need_rs2
);

  always_comb begin
    need_rs1 = 1'b0;
    need_rs2 = 1'b0;
    case (opcode)
      OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: begin
        need_rs1 = 1'b1;
        need_rs2 = 1'b1;
      end
      OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: begin
        need_rs1 = 1'b1;
      end
      default: begin
        // LUI, AUIPC, JAL and unknown opcodes read no registers.
      end
    endcase
  end

endmodule

// File: rtl/register_file_read_control.sv
// Source-operand fetch for the current instruction. The register file has a
// single asynchronous read port, so rs1 and rs2 are read one per cycle by a
// small FSM (IDLE -> RD_RS1 -> RD_RS2 -> DONE). The stage sequencer holds
// STAGE_REGISTER_READ until operands_valid is seen.
// Optional feature macro: RF_BYPASS_EN -- when defined, a writeback in the
// same cycle to the register being read is forwarded (wb_value) instead of
// the stale register-file data.
// Ports:
//   clk, reset (sync, active-high)
//   stage            in   current CPU stage
//   opcode, rs1, rs2 in   decoded instruction fields (latched at start)
//   rf_read_addr     out  register-file read address (from state)
//   rf_read_data     in   register-file asynchronous read data
//   wb_write_enable, wb_rd, wb_value  in  writeback bus (bypass build only)
//   rs1_value, rs2_value  out  captured operands
//   operands_valid   out  state is DONE
//   busy             out  a read is in progress (RD_RS1 / RD_RS2)
module register_file_read_control
  import register_file_read_control_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] stage,
  input  logic [6:0]             opcode,
  input  logic [REG_ADDR_W-1:0]  rs1,
  input  logic [REG_ADDR_W-1:0]  rs2,
  output logic [REG_ADDR_W-1:0]  rf_read_addr,
  input  logic [XLEN-1:0]        rf_read_data,
  input  logic                   wb_write_enable,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]        wb_value,
  output logic [XLEN-1:0]        rs1_value,
  output logic [XLEN-1:0]        rs2_value,
  output logic                   operands_valid,
  output logic                   busy
);

  rfr_state_e state_reg, state_next;
  logic [REG_ADDR_W-1:0] rs1_idx_reg, rs2_idx_reg;
  logic                  need_rs2_reg;
  logic [XLEN-1:0]       rs1_value_reg, rs2_value_reg;
  logic                  need_rs1, need_rs2;
  logic                  in_read_stage;
  logic [XLEN-1:0]       capture_value;

  operand_usage_decode u_operand_usage_decode (
    .opcode   (opcode),
    .need_rs1 (need_rs1),
    .need_rs2 (need_rs2)
  );

  assign in_read_stage = (stage == STAGE_REGISTER_READ);

  // Next state and read address.
  always_comb begin
    state_next   = state_reg;
    rf_read_addr = '0;
    case (state_reg)
      RFR_STATE_IDLE: begin
        if (in_read_stage)
          state_next = need_rs1 ? RFR_STATE_RD_RS1 : RFR_STATE_DONE;
      end
      RFR_STATE_RD_RS1: begin
        rf_read_addr = rs1_idx_reg;
        if (!in_read_stage)
          state_next = RFR_STATE_IDLE;
        else
          state_next = need_rs2_reg ? RFR_STATE_RD_RS2 : RFR_STATE_DONE;
      end
      RFR_STATE_RD_RS2: begin
        rf_read_addr = rs2_idx_reg;
        state_next   = in_read_stage ? RFR_STATE_DONE : RFR_STATE_IDLE;
      end
      RFR_STATE_DONE: begin
        if (!in_read_stage)
          state_next = RFR_STATE_IDLE;
      end
      default: state_next = RFR_STATE_IDLE;
    endcase
  end

  // Value captured in a read state. rf_read_addr is the index being read
  // (always 0 outside the read states, where nothing is captured).
`ifdef RF_BYPASS_EN
  always_comb begin
    if (rf_read_addr == '0)
      capture_value = '0;
    else if (wb_write_enable && (wb_rd == rf_read_addr))
      capture_value = wb_value;
    else
      capture_value = rf_read_data;
  end
`else
  assign capture_value = (rf_read_addr == '0) ? '0 : rf_read_data;

  // Writeback bus is only consumed by the bypass build.
  logic unused_wb;
  assign unused_wb = ^{wb_write_enable, wb_rd, wb_value};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RFR_STATE_IDLE;
      rs1_idx_reg   <= '0;
      rs2_idx_reg   <= '0;
      need_rs2_reg  <= 1'b0;
      rs1_value_reg <= '0;
      rs2_value_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        RFR_STATE_IDLE: begin
          if (in_read_stage) begin
            rs1_idx_reg   <= rs1;
            rs2_idx_reg   <= rs2;
            need_rs2_reg  <= need_rs2;
            rs1_value_reg <= '0;
            rs2_value_reg <= '0;
          end
        end
        // On abort (stage left) nothing is captured; old values are kept.
        RFR_STATE_RD_RS1: if (in_read_stage) rs1_value_reg <= capture_value;
        RFR_STATE_RD_RS2: if (in_read_stage) rs2_value_reg <= capture_value;
        default: begin
        end
      endcase
    end
  end

  assign rs1_value      = rs1_value_reg;
  assign rs2_value      = rs2_value_reg;
  assign operands_valid = (state_reg == RFR_STATE_DONE);
  assign busy           = (state_reg == RFR_STATE_RD_RS1) || (state_reg == RFR_STATE_RD_RS2);

endmodule

// File: tb/tb_register_file_read_control.sv
module tb_register_file_read_control;
  import register_file_read_control_pkg::*;

  logic                   clk;
  logic                   reset;
  logic [STAGE_WIDTH-1:0] stage;
  logic [6:0]             opcode;
  logic [4:0]             rs1, rs2;
  logic [4:0]             rf_read_addr;
  logic [31:0]            rf_read_data;
  logic                   wb_write_enable;
  logic [4:0]             wb_rd;
  logic [31:0]            wb_value;
  logic [31:0]            rs1_value, rs2_value;
  logic                   operands_valid;
  logic                   busy;

  logic [31:0] rf_mem [32];
  int checks_count = 0;
  int errors_count = 0;

  register_file_read_control #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .stage           (stage),
    .opcode          (opcode),
    .rs1             (rs1),
    .rs2             (rs2),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data),
    .wb_write_enable (wb_write_enable),
    .wb_rd           (wb_rd),
    .wb_value        (wb_value),
    .rs1_value       (rs1_value),
    .rs2_value       (rs2_value),
    .operands_valid  (operands_valid),
    .busy            (busy)
  );

  // Register file with asynchronous read.
  assign rf_read_data = rf_mem[rf_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_count++;
    if (obs !== exp) begin
      errors_count++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Number of source registers an opcode reads (0, 1 = rs1, 2 = rs1+rs2).
  function automatic int operand_count(input logic [6:0] op);
    if (op == OPCODE_OP || op == OPCODE_BRANCH || op == OPCODE_STORE) return 2;
    if (op == OPCODE_OP_IMM || op == OPCODE_LOAD || op == OPCODE_JALR) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wen,
                                             input logic [4:0] wrd, input logic [31:0] wval);
    if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wen && wrd == idx) return wval;
`endif
    return rf_mem[idx];
  endfunction

  // One full operand fetch; called #1 after a posedge with the DUT in IDLE.
  task automatic run_txn(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wval,
                         input bit hold_done);
    logic [4:0]  addr_q[$];
    logic [31:0] e1, e2;
    int n;
    n = operand_count(op);
    addr_q = {};
    e1 = 32'd0;
    e2 = 32'd0;
    if (n >= 1) begin addr_q.push_back(r1); e1 = model_read(r1, wen, wrd, wval); end
    if (n == 2) begin addr_q.push_back(r2); e2 = model_read(r2, wen, wrd, wval); end
    stage = STAGE_REGISTER_READ; opcode = op; rs1 = r1; rs2 = r2;
    wb_write_enable = wen; wb_rd = wrd; wb_value = wval;
    #1;
    check("addr_idle", {27'd0, rf_read_addr}, 32'd0);
    for (int k = 0; k < addr_q.size(); k++) begin
      @(posedge clk); #1;
      check("busy_read", {31'd0, busy}, 32'd1);
      check("valid_read", {31'd0, operands_valid}, 32'd0);
      check("addr_read", {27'd0, rf_read_addr}, {27'd0, addr_q[k]});
      // Decoder fields may change after start; the latched copies must be used.
      opcode = 7'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    end
    @(posedge clk); #1;
    check("valid_done", {31'd0, operands_valid}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("addr_done", {27'd0, rf_read_addr}, 32'd0);
    check("rs1_value", rs1_value, e1);
    check("rs2_value", rs2_value, e2);
    $display("txn op=%07b rs1=%0d rs2=%0d rs1_value=%08h rs2_value=%08h", op, r1, r2, rs1_value, rs2_value);
    if (hold_done) begin
      @(posedge clk); #1;
      check("valid_hold", {31'd0, operands_valid}, 32'd1);
    end
    stage = STAGE_EXECUTE;
    @(posedge clk); #1;
    check("valid_exit", {31'd0, operands_valid}, 32'd0);
    check("busy_exit", {31'd0, busy}, 32'd0);
  endtask

  logic [6:0] op_table [10];

  initial begin
    op_table = '{OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
                 OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP, 7'b1111111};
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    reset = 1'b1; stage = STAGE_REGISTER_READ; opcode = OPCODE_OP; rs1 = 5'd1; rs2 = 5'd2;
    wb_write_enable = 1'b0; wb_rd = 5'd0; wb_value = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, operands_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {27'd0, rf_read_addr}, 32'd0);
    check("rst_rs1", rs1_value, 32'd0);
    check("rst_rs2", rs2_value, 32'd0);
    reset = 1'b0; stage = STAGE_FETCH;
    @(posedge clk); #1;

    // ADD x3,x1,x2
    rf_mem[1] = 32'd5; rf_mem[2] = 32'd7;
    run_txn(OPCODE_OP, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
    // ADDI with rs1=x4
    rf_mem[4] = 32'hDEADBEEF;
    run_txn(OPCODE_OP_IMM, 5'd4, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0);
    // LUI
    run_txn(OPCODE_LUI, 5'd4, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0);
    // BEQ x0,x6 with every RF location reading all-ones
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hFFFFFFFF;
    run_txn(OPCODE_BRANCH, 5'd0, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    // Writeback forwarding cases
    rf_mem[9] = 32'h1;
    run_txn(OPCODE_OP_IMM, 5'd9, 5'd0, 1'b1, 5'd9, 32'h12345678, 1'b0);
    run_txn(OPCODE_OP, 5'd3, 5'd9, 1'b1, 5'd9, 32'h12345678, 1'b0);
    run_txn(OPCODE_OP_IMM, 5'd9, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0);
    run_txn(OPCODE_STORE, 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0);

    // Reset while in RD_RS2 (rs1 already captured)
    rf_mem[1] = 32'd5;
    stage = STAGE_REGISTER_READ; opcode = OPCODE_OP; rs1 = 5'd1; rs2 = 5'd2;
    wb_write_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_rs1", rs1_value, 32'd5);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, operands_valid}, 32'd0);
    check("midrst_rs1", rs1_value, 32'd0);
    check("midrst_addr", {27'd0, rf_read_addr}, 32'd0);
    reset = 1'b0; stage = STAGE_FETCH;
    @(posedge clk); #1;

    // Reset while in RD_RS1
    stage = STAGE_REGISTER_READ;
    @(posedge clk); #1;
    check("rs1st_addr", {27'd0, rf_read_addr}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst1_busy", {31'd0, busy}, 32'd0);
    check("rst1_valid", {31'd0, operands_valid}, 32'd0);
    check("rst1_rs1", rs1_value, 32'd0);
    check("rst1_rs2", rs2_value, 32'd0);
    reset = 1'b0; stage = STAGE_FETCH;
    @(posedge clk); #1;

    // Stage dropped in RD_RS2: abort with no valid pulse
    stage = STAGE_REGISTER_READ; opcode = OPCODE_OP; rs1 = 5'd1; rs2 = 5'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_addr", {27'd0, rf_read_addr}, 32'd2);
    stage = STAGE_EXECUTE;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, operands_valid}, 32'd0);
    @(posedge clk); #1;
    check("abort_valid2", {31'd0, operands_valid}, 32'd0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [6:0] op;
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : op_table[$urandom_range(0, 9)];
      run_txn(op, 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
              $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
    $finish;
  end

endmodule
